exti_controller: RTL and testbench

EXTI_CONTROLLER -- requirements
Module: exti_controller

---
 rtl/exti_pkg.sv | 20 ++
 rtl/exti_prio_enc.sv | 29 ++
 rtl/exti_controller.sv | 104 ++++++++++
 tb/tb_exti_controller.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/exti_pkg.sv
// ---------------------------------------------------------------------------
// exti_pkg : shared defaults and FSM state encoding for the EXTI controller
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package exti_pkg;

  localparam int NUM_LINES_DEF = 21;
  localparam int ID_W_DEF      = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/exti_prio_enc.sv
// ---------------------------------------------------------------------------
// exti_prio_enc : combinational lowest-index-first priority encoder
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exti_prio_enc
  import exti_pkg::*;
#(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int ID_W      = ID_W_DEF
) (
  input  logic [NUM_LINES-1:0] req,
  output logic                 valid,
  output logic [ID_W-1:0]      idx
);

  // Scanning downward lets the lowest set index overwrite all higher ones.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/exti_controller.sv
// ---------------------------------------------------------------------------
// exti_controller : pending-register latch and single-request IRQ handshake FSM
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exti_controller
  import exti_pkg::*;
#(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int ID_W      = ID_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] EDGE_DETECTED,
  input  logic [NUM_LINES-1:0] EXTI_IMR,
  input  logic [NUM_LINES-1:0] EXTI_SWIER,
  input  logic [NUM_LINES-1:0] PR_CLR,
  input  logic                 IRQ_ACK,
  input  logic                 IRQ_DONE,
  output logic [NUM_LINES-1:0] EXTI_PR,
  output logic                 IRQ_VALID,
  output logic [ID_W-1:0]      IRQ_ID,
  output logic                 IRQ_ACTIVE,
  output logic [ID_W-1:0]      ACTIVE_ID
);

  state_t               state;
  state_t               state_next;
  logic [NUM_LINES-1:0] pr;
  logic [NUM_LINES-1:0] pr_next;
  logic [NUM_LINES-1:0] set_vec;
  logic [NUM_LINES-1:0] clr_vec;
  logic [NUM_LINES-1:0] id_mask;
  logic [NUM_LINES-1:0] eligible;
  logic                 ack_accept;
  logic                 still_eligible;
  logic                 win_valid;
  logic [ID_W-1:0]      win_idx;
  logic [ID_W-1:0]      irq_id;
  logic [ID_W-1:0]      active_id;
  logic                 valid_q;
  logic                 active_q;

  assign set_vec    = (EDGE_DETECTED | EXTI_SWIER) & EXTI_IMR;
  assign id_mask    = {{(NUM_LINES-1){1'b0}}, 1'b1} << irq_id;
  assign ack_accept = (state == ST_REQ) && IRQ_ACK;
  assign clr_vec    = PR_CLR | (ack_accept ? id_mask : '0);
  // Set wins over any clear landing on the same bit in the same cycle.
  assign pr_next    = (pr & ~clr_vec) | set_vec;
  assign eligible   = pr & EXTI_IMR;

  // Presented line stays requested only if it survives this cycle's clears and mask.
  assign still_eligible = |(pr_next & EXTI_IMR & id_mask);

  exti_prio_enc #(
    .NUM_LINES (NUM_LINES),
    .ID_W      (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (win_valid) state_next = ST_REQ;
      ST_REQ: begin
        if (IRQ_ACK)              state_next = ST_ACTIVE;
        else if (!still_eligible) state_next = ST_IDLE;
      end
      ST_ACTIVE: if (IRQ_DONE) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pr        <= '0;
      irq_id    <= '0;
      active_id <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state    <= state_next;
      pr       <= pr_next;
      valid_q  <= (state_next == ST_REQ);
      active_q <= (state_next == ST_ACTIVE);
      if (state == ST_IDLE && win_valid) irq_id <= win_idx;
      if (ack_accept) active_id <= irq_id;
    end
  end

  assign EXTI_PR    = pr;
  assign IRQ_VALID  = valid_q;
  assign IRQ_ID     = irq_id;
  assign IRQ_ACTIVE = active_q;
  assign ACTIVE_ID  = active_id;

endmodule

`default_nettype wire

// File: tb/tb_exti_controller.sv
// ---------------------------------------------------------------------------
// tb_exti_controller : directed bench for exti_controller
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_exti_controller;

  localparam int NL = 21;
  localparam int IW = 5;
  localparam logic [NL-1:0] ALL = {NL{1'b1}};

  logic          clk = 1'b0;
  logic          rst;
  logic [NL-1:0] edge_det, imr, swier, pr_clr;
  logic          ack, done;
  logic [NL-1:0] pr;
  logic          irq_valid, irq_active;
  logic [IW-1:0] irq_id, active_id;

  int checks = 0;
  int errors = 0;

  exti_controller #(.NUM_LINES(NL), .ID_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .EDGE_DETECTED (edge_det),
    .EXTI_IMR      (imr),
    .EXTI_SWIER    (swier),
    .PR_CLR        (pr_clr),
    .IRQ_ACK       (ack),
    .IRQ_DONE      (done),
    .EXTI_PR       (pr),
    .IRQ_VALID     (irq_valid),
    .IRQ_ID        (irq_id),
    .IRQ_ACTIVE    (irq_active),
    .ACTIVE_ID     (active_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; edge_det = '0; imr = ALL; swier = '0; pr_clr = '0; ack = 1'b0; done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pr", 32'(pr), 32'h0);
    chk("rst_valid", 32'(irq_valid), 32'h0);
    chk("rst_active", 32'(irq_active), 32'h0);
    chk("rst_irq_id", 32'(irq_id), 32'h0);
    chk("rst_active_id", 32'(active_id), 32'h0);

    // Single line latency
    edge_det = 21'h000008; tick(); edge_det = '0;
    chk("l3_pr", 32'(pr), 32'h000008);
    chk("l3_valid_early", 32'(irq_valid), 32'h0);
    tick();
    chk("l3_valid", 32'(irq_valid), 32'h1);
    chk("l3_id", 32'(irq_id), 32'd3);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("l3_active", 32'(irq_active), 32'h1);
    chk("l3_active_id", 32'(active_id), 32'd3);
    chk("l3_pr_clr", 32'(pr), 32'h0);
    done = 1'b1; tick(); done = 1'b0;
    chk("l3_done", 32'(irq_active), 32'h0);

    // Lines 5 and 2 together, plus no preemption and re-latch during ACTIVE
    edge_det = 21'h000024; tick(); edge_det = '0;
    chk("p_pr", 32'(pr), 32'h000024);
    tick();
    chk("p_id2", 32'(irq_id), 32'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("p_pr_after_ack", 32'(pr), 32'h000020);
    chk("p_active_id2", 32'(active_id), 32'd2);
    edge_det = 21'h000004; tick(); edge_det = '0;
    chk("p_relatch", 32'(pr), 32'h000024);
    done = 1'b1; tick(); done = 1'b0;
    chk("p_idle_gap", 32'(irq_valid), 32'h0);
    tick();
    chk("p_valid_next", 32'(irq_valid), 32'h1);
    chk("p_id_next", 32'(irq_id), 32'd2);
    edge_det = 21'h000001; tick(); edge_det = '0;
    chk("p_no_preempt", 32'(irq_id), 32'd2);
    chk("p_pr_l0", 32'(pr), 32'h000025);
    ack = 1'b1; tick(); ack = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    tick();
    chk("p_id0", 32'(irq_id), 32'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    tick();
    chk("p_id5", 32'(irq_id), 32'd5);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("p_pr_empty", 32'(pr), 32'h0);
    done = 1'b1; tick(); done = 1'b0;

    // Masked line 7
    imr = ALL & ~21'h000080;
    edge_det = 21'h000080; tick(); edge_det = '0;
    chk("m7_pr", 32'(pr), 32'h0);
    tick();
    chk("m7_valid", 32'(irq_valid), 32'h0);
    imr = ALL;

    // Withdraw via PR_CLR, then PR_CLR with ACK
    edge_det = 21'h000010; tick(); edge_det = '0; tick();
    chk("w4_id", 32'(irq_id), 32'd4);
    pr_clr = 21'h000010; tick(); pr_clr = '0;
    chk("w4_withdraw", 32'(irq_valid), 32'h0);
    chk("w4_pr", 32'(pr), 32'h0);
    tick();
    chk("w4_stay_idle", 32'(irq_valid), 32'h0);
    edge_det = 21'h000010; tick(); edge_det = '0; tick();
    pr_clr = 21'h000010; ack = 1'b1; tick(); pr_clr = '0; ack = 1'b0;
    chk("w4_ack_wins", 32'(irq_active), 32'h1);
    chk("w4_ack_id", 32'(active_id), 32'd4);
    done = 1'b1; tick(); done = 1'b0;

    // Withdraw via mask keeps the pending bit
    edge_det = 21'h000200; tick(); edge_det = '0; tick();
    chk("w9_id", 32'(irq_id), 32'd9);
    imr = ALL & ~21'h000200; tick();
    chk("w9_withdraw", 32'(irq_valid), 32'h0);
    chk("w9_pr_kept", 32'(pr), 32'h000200);
    imr = ALL; tick();
    chk("w9_rearb", 32'(irq_valid), 32'h1);
    pr_clr = 21'h000200; tick(); pr_clr = '0;
    chk("w9_clr", 32'(irq_valid), 32'h0);

    // Set wins over clear; software trigger on top line
    pr_clr = 21'h000040; edge_det = 21'h000040; tick(); pr_clr = '0; edge_det = '0;
    chk("s6_set_wins", 32'(pr), 32'h000040);
    tick();
    chk("s6_id", 32'(irq_id), 32'd6);
    pr_clr = 21'h000040; tick(); pr_clr = '0;
    swier = 21'h100000; tick(); swier = '0; tick();
    chk("sw20_valid", 32'(irq_valid), 32'h1);
    chk("sw20_id", 32'(irq_id), 32'd20);
    ack = 1'b1; tick(); ack = 1'b0;

    // Reset during ACTIVE with every line pending
    edge_det = ALL; tick();
    chk("r_pr_full", 32'(pr), 32'h1FFFFF);
    chk("r_active", 32'(irq_active), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0; edge_det = '0;
    chk("r_pr", 32'(pr), 32'h0);
    chk("r_active0", 32'(irq_active), 32'h0);
    chk("r_valid0", 32'(irq_valid), 32'h0);
    chk("r_ids", 32'({irq_id, active_id}), 32'h0);
    tick();
    chk("r_after", 32'(irq_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
